// File: rtl/dsp_add_arbiter.sv
// Round-robin sequencer that time-shares one external combinational 32-bit adder
// among NREQ requesters: grant, feed registered operands, capture sum/carry, hold response.
module dsp_add_arbiter #(
    parameter int NREQ = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [31:0]          rsp_sum,
    output logic                 rsp_carry,
    output logic [31:0]          add_in1,
    output logic [31:0]          add_in2,
    input  logic [31:0]          add_out,
    output logic                 busy
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_reg;
    logic [IW-1:0]   last_reg;
    logic [IW-1:0]   owner_reg;
    logic [31:0]     op_a_reg;
    logic [31:0]     op_b_reg;
    logic [31:0]     sum_reg;
    logic            carry_reg;
    logic [NREQ-1:0] rsp_valid_reg;

    logic [31:0]     a_arr    [NREQ];
    logic [31:0]     b_arr    [NREQ];
    logic [IW-1:0]   cand_idx [NREQ];
    logic            grant_found;
    logic [IW-1:0]   grant_idx;

    // cand_idx[k] is the requester checked k-th, starting just after the last winner.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            logic [IW:0] rot_sum;
            assign a_arr[gi]    = req_a[32*gi +: 32];
            assign b_arr[gi]    = req_b[32*gi +: 32];
            assign rot_sum      = {1'b0, last_reg} + (IW+1)'(gi + 1);
            assign cand_idx[gi] = (rot_sum >= (IW+1)'(NREQ))
                                  ? IW'(rot_sum - (IW+1)'(NREQ))
                                  : IW'(rot_sum);
        end
    endgenerate

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[cand_idx[k]]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx[k];
            end
        end
    end

    // Held low while reset is asserted so no handshake can complete during reset.
    always_comb begin
        req_ready = '0;
        if (rst_n && state_reg == IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            last_reg      <= IW'(NREQ - 1);
            owner_reg     <= '0;
            op_a_reg      <= '0;
            op_b_reg      <= '0;
            sum_reg       <= '0;
            carry_reg     <= 1'b0;
            rsp_valid_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_found) begin
                        op_a_reg  <= a_arr[grant_idx];
                        op_b_reg  <= b_arr[grant_idx];
                        owner_reg <= grant_idx;
                        last_reg  <= grant_idx;
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    // A wrapped 32-bit sum is smaller than either operand exactly when A+B overflows.
                    sum_reg       <= add_out;
                    carry_reg     <= (add_out < op_a_reg);
                    rsp_valid_reg <= {{(NREQ-1){1'b0}}, 1'b1} << owner_reg;
                    state_reg     <= RESP;
                end
                RESP: begin
                    if (rsp_ready[owner_reg]) begin
                        rsp_valid_reg <= '0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_reg <= '0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign add_in1   = op_a_reg;
    assign add_in2   = op_b_reg;
    assign rsp_sum   = sum_reg;
    assign rsp_carry = carry_reg;
    assign rsp_valid = rsp_valid_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_dsp_add_arbiter.sv
// Directed + randomized bench for dsp_add_arbiter with NREQ=3 and a behavioural adder.
module tb_dsp_add_arbiter;

    localparam int N = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [32*N-1:0] req_a;
    logic [32*N-1:0] req_b;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready;
    logic [31:0]     rsp_sum;
    logic            rsp_carry;
    logic [31:0]     add_in1;
    logic [31:0]     add_in2;
    logic [31:0]     add_out;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Requester-side view and reference state
    logic [N-1:0] valid_v;
    logic [31:0]  av [N];
    logic [31:0]  bv [N];
    int           last_m;

    dsp_add_arbiter #(.NREQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .add_in1   (add_in1),
        .add_in2   (add_in2),
        .add_out   (add_out),
        .busy      (busy)
    );

    // Stand-in for the shared DSP adder
    assign add_out = add_in1 + add_in2;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        req_valid = valid_v;
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = av[i];
            req_b[32*i +: 32] = bv[i];
        end
    endtask

    // Called just after a rising edge that starts an IDLE cycle, with requests driven.
    // Returns just after the rising edge that brings the block back to IDLE.
    task automatic run_op(input int resp_delay, output int w);
        logic [31:0]  ea;
        logic [31:0]  eb;
        logic [32:0]  full;
        logic [N-1:0] oh;
        int           c;
        w = -1;
        for (int k = 1; k <= N; k++) begin
            c = (last_m + k) % N;
            if (w < 0 && valid_v[c]) w = c;
        end
        if (w < 0) w = 0;
        ea   = av[w];
        eb   = bv[w];
        full = {1'b0, ea} + {1'b0, eb};
        oh   = '0;
        oh[w] = 1'b1;

        @(negedge clk);
        check("grant", req_ready, oh);
        check("idle_busy", busy, 0);
        check("idle_rsp_valid", rsp_valid, 0);
        last_m = w;
        @(posedge clk); #1;

        @(negedge clk);
        check("exec_busy", busy, 1);
        check("exec_rsp_valid", rsp_valid, 0);
        check("exec_req_ready", req_ready, 0);
        check("exec_add_in1", add_in1, ea);
        check("exec_add_in2", add_in2, eb);
        @(posedge clk); #1;

        for (int d = 0; d <= resp_delay; d++) begin
            @(negedge clk);
            check("resp_valid", rsp_valid, oh);
            check("resp_sum", rsp_sum, full[31:0]);
            check("resp_carry", rsp_carry, full[32]);
            check("resp_req_ready", req_ready, 0);
            check("resp_busy", busy, 1);
            // Non-owners raising rsp_ready must not release the response.
            rsp_ready = (d == resp_delay) ? oh : ~oh;
            @(posedge clk); #1;
        end
        rsp_ready = '0;
        $display("op: owner=%0d a=0x%08h b=0x%08h sum=0x%08h carry=%0d hold=%0d",
                 w, ea, eb, full[31:0], full[32], resp_delay);
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        valid_v[i] = 1'b1;
        av[i] = a;
        bv[i] = b;
    endtask

    initial begin
        int w;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = '0;
        valid_v   = '0;
        for (int i = 0; i < N; i++) begin
            av[i] = '0;
            bv[i] = '0;
        end
        last_m = N - 1;

        // Reset state
        #12;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_sum", rsp_sum, 0);
        check("rst_rsp_carry", rsp_carry, 0);
        check("rst_add_in1", add_in1, 0);
        check("rst_add_in2", add_in2, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed sums
        set_req(0, 32'h0000_FFFF, 32'h0000_0001);
        drive();
        run_op(0, w);
        valid_v[0] = 1'b0;
        set_req(1, 32'hFFFF_FFFF, 32'h0000_0002);
        drive();
        run_op(0, w);
        valid_v[1] = 1'b0;
        set_req(2, 32'h8000_0000, 32'h8000_0000);
        drive();
        run_op(1, w);
        valid_v = '0;
        drive();

        // Contention between 0 and 1 straight after reset
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst2_busy", busy, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        last_m = N - 1;
        @(posedge clk); #1;
        set_req(0, 32'h1111_0000, 32'h0000_1111);
        set_req(1, 32'hF000_0000, 32'h2000_0005);
        drive();
        for (int j = 0; j < 4; j++) run_op(0, w);

        // All three contending after reset
        valid_v = '0;
        drive();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        last_m = N - 1;
        @(posedge clk); #1;
        set_req(0, 32'h0000_0010, 32'h0000_0020);
        set_req(1, 32'h7FFF_FFFF, 32'h0000_0001);
        set_req(2, 32'hDEAD_BEEF, 32'h3333_3333);
        drive();
        for (int j = 0; j < 4; j++) run_op(0, w);

        // Long response hold with another requester waiting
        valid_v[2] = 1'b0;
        drive();
        run_op(5, w);
        run_op(0, w);

        // Reset in the middle of RESP
        valid_v = '0;
        drive();
        set_req(0, 32'h0000_0003, 32'h0000_0004);
        drive();
        @(negedge clk);
        check("mresp_grant", req_ready, 3'b001);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("mresp_valid_before", rsp_valid, 3'b001);
        rst_n = 1'b0;
        #1;
        check("mresp_valid_after", rsp_valid, 0);
        check("mresp_sum", rsp_sum, 0);
        check("mresp_carry", rsp_carry, 0);
        check("mresp_add_in1", add_in1, 0);
        check("mresp_busy", busy, 0);
        check("mresp_req_ready", req_ready, 0);
        valid_v = '0;
        drive();
        @(negedge clk);
        rst_n  = 1'b1;
        last_m = N - 1;
        @(posedge clk); #1;

        // Reset in the middle of EXEC
        set_req(0, 32'h0000_0100, 32'h0000_0200);
        drive();
        @(negedge clk);
        check("mexec_grant", req_ready, 3'b001);
        @(posedge clk); #1;
        valid_v = '0;
        drive();
        @(negedge clk);
        check("mexec_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mexec_busy_rst", busy, 0);
        check("mexec_add_in1", add_in1, 0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        last_m = N - 1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("mexec_no_rsp", rsp_valid, 0);
            check("mexec_idle", busy, 0);
        end
        @(posedge clk); #1;
        set_req(0, 32'h0000_0100, 32'h0000_0200);
        set_req(1, 32'h1234_5678, 32'h0000_0001);
        drive();
        run_op(0, w);
        check("mexec_tie_winner", w, 0);

        // Randomized traffic against the reference model
        for (int j = 0; j < 24; j++) begin
            if ($urandom_range(1, 0) == 1) begin
                valid_v[w] = 1'b0;
            end else begin
                av[w] = $urandom;
                bv[w] = $urandom;
            end
            for (int i = 0; i < N; i++) begin
                if (!valid_v[i] && $urandom_range(1, 0) == 1) begin
                    set_req(i, $urandom, $urandom);
                end
            end
            if (valid_v == '0) set_req(0, $urandom, $urandom);
            drive();
            run_op(int'($urandom_range(3, 0)), w);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dsp_add_arbiter.md
# dsp_add_arbiter

Round-robin arbiter and sequencer that shares one combinational DSP-based 32-bit adder (SB_MAC16 in bypassed add mode) among `NREQ` requesters in the sail-core. It owns the adder's operand inputs, takes operand pairs over a valid/ready handshake, and registers the adder output. It returns the sum and a derived carry to the winning requester, which holds the response until that requester accepts it. The adder's operand inputs are driven from registers, so the adder sees stable inputs for a full cycle.

## Interface
- `NREQ`, 2: number of requesters; legal values are 2 to 4.
- `clk` in 1: single clock; every state element is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NREQ: requester i has an operand pair pending.
- `req_a` in 32*NREQ: operand A; requester i uses bits [32i+31:32i].
- `req_b` in 32*NREQ: operand B, packed the same way as `req_a`.
- `req_ready` out NREQ: one-hot; handshake completes in a cycle where `req_valid[i]` and `req_ready[i]` are both high.
- `rsp_valid` out NREQ: one-hot; the response belongs to requester i.
- `rsp_ready` in NREQ: requester i accepts the response.
- `rsp_sum` out 32: registered result, (A+B) mod 2^32.
- `rsp_carry` out 1: registered carry-out of A+B.
- `add_in1` out 32: operand to the shared adder (input1).
- `add_in2` out 32: operand to the shared adder (input2).
- `add_out` in 32: sum from the shared adder (combinational).
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- The FSM has three states: IDLE, EXEC and RESP.
- **IDLE**
  - If any `req_valid` is high, pick winner w by round-robin: search starts at `last+1` (mod NREQ), first valid wins.
  - `req_ready[w]` is driven high combinationally in this same cycle.
  - On the edge: A and B load into the operand registers, `owner<=w`, `last<=w`, then go to EXEC.
- **EXEC**
  - `add_in1`/`add_in2` come from the operand registers.
  - On the edge: `rsp_sum<=add_out`, `rsp_carry<=(add_out < opA)` as an unsigned compare, then go to RESP.
- **RESP**
  - `rsp_valid[owner]=1`; `rsp_sum` and `rsp_carry` are held stable.
  - When `rsp_ready[owner]` is high, go to IDLE on the edge.
  - `rsp_ready` bits of non-owners are ignored.
- `req_ready` is 0 in EXEC and RESP; only one operation is in flight.
- Requester rules: `req_valid`, `req_a` and `req_b` must stay stable until `req_ready`. `req_valid` may not be withdrawn before the grant. The bench treats a violation as an error.
- Operand registers, and therefore `add_in1`/`add_in2`, hold their last values outside EXEC; they are not cleared after an operation.
- Reset (asynchronous, at any point, including mid-EXEC or mid-RESP):
  - state=IDLE, `last=NREQ-1` (requester 0 has first priority).
  - Operand registers, `rsp_sum`, `rsp_carry` and `owner` are cleared to 0.
  - An in-flight operation is discarded; no response is produced.
- Reset values of outputs: `req_ready=0` (combinational; may rise in the first IDLE cycle after reset), `rsp_valid=0`, `rsp_sum=0`, `rsp_carry=0`, `add_in1=0`, `add_in2=0`, `busy=0`.

## Timing
- Accept in cycle T (`req_ready` high) → EXEC in T+1 → `rsp_valid` high from T+2.
- Response is consumed in the first cycle ≥T+2 where `rsp_ready[owner]` is high; the next accept is possible in the following cycle.
- Best-case throughput is one operation per 3 cycles.
- Simultaneous requests: exactly one grant per IDLE cycle. Under continuous contention, requesters are served in strict rotation.
- A request arriving while the block is busy waits; it is considered at the next IDLE cycle.
- `req_ready` depends combinationally on `req_valid` and state. There is no combinational path from `rsp_ready` to `req_ready`.
- Critical path: operand registers → adder → `rsp_sum`/`rsp_carry` registers, within one cycle.

## Test plan
- Reset with all requests idle → all outputs 0 and `busy=0`. Asserting `rst_n` low mid-RESP drops `rsp_valid` to 0 immediately.
- Requester 0 sends A=0x0000_FFFF, B=0x0000_0001 → `req_ready[0]` at T, `rsp_valid[0]` at T+2, `rsp_sum=0x0001_0000`, `rsp_carry=0`.
- Requester 1 sends A=0xFFFF_FFFF, B=0x0000_0002 → `rsp_sum=0x0000_0001`, `rsp_carry=1`. Also check 0x8000_0000+0x8000_0000 → sum 0, carry 1.
- After reset, requesters 0 and 1 both hold `req_valid` with distinct operands for 4 operations → grant order 0,1,0,1 with sums matching the owners. With NREQ=3 and all three valid, the order is 0,1,2,0.
- Hold `rsp_ready` low for 5 cycles in RESP while another requester is valid → `rsp_valid`, `rsp_sum` and `rsp_carry` stay stable and `req_ready` stays 0. After `rsp_ready`, the waiting requester is granted the next cycle.
- Pulse `rst_n` low during EXEC → no `rsp_valid` appears. The next request from requester 0 completes normally and requester 0 wins a tie against requester 1.
